// File: rtl/rs_pkg.sv
// Shared types for the age-ordered reservation station.
// rs_entry_t is one RS slot: payload, two operands and their ready bits.
// Operand and payload widths are fixed here. The top's XLEN and PKT_W
// parameters must match RS_XLEN and RS_PKT_W.
package rs_pkg;
  localparam int RS_DEPTH = 16;
  localparam int RS_XLEN  = 32;
  localparam int RS_PKT_W = 64;
  localparam int IDX_W    = $clog2(RS_DEPTH);

  typedef struct packed {
    logic                valid;
    logic [RS_PKT_W-1:0] pkt;
    logic [RS_XLEN-1:0]  src1;
    logic [RS_XLEN-1:0]  src2;
    logic                src1_rdy;
    logic                src2_rdy;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the RS.
//   clock, reset : clock, async active-high reset
//   valid        : entries resident before this edge
//   alloc        : entries written this cycle. Lower index means an older
//                  slot, because allocation hands out entries in slot order.
//   elig         : entries ready to issue
//   older_cnt    : per entry, the number of eligible entries older than it.
//                  The oldest eligible entry has count 0.
// age_q[i][j] = 1 means entry i is older than entry j.
module rs_age_matrix import rs_pkg::*; #(
  parameter int DEPTH = RS_DEPTH,
  parameter int CNT_W = IDX_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0]            alloc,
  input  logic [DEPTH-1:0]            elig,
  output logic [DEPTH-1:0][CNT_W-1:0] older_cnt
);
  logic [DEPTH-1:0][DEPTH-1:0] age_q;

  // A new entry is younger than every resident entry and every entry
  // allocated with a lower index this cycle. Stale bits against invalid
  // entries are harmless: they are masked by elig and rewritten on reuse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) age_q <= '0;
    else begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (alloc[i])      age_q[i][j] <= alloc[j] && (j > i);
          else if (alloc[j]) age_q[i][j] <= valid[i];
    end
  end

  always_comb begin
    older_cnt = '0;
    for (int j = 0; j < DEPTH; j++)
      for (int i = 0; i < DEPTH; i++)
        older_cnt[j] = older_cnt[j] + CNT_W'(elig[i] & age_q[i][j]);
  end
endmodule

// File: rtl/rs_age_issue.sv
// N-way reservation station with oldest-first issue.
//   clock, reset    : clock, async active-high reset
//   squash          : flush all entries at the next edge
//   disp_*          : DISP_W dispatch slots. disp_ready is derived from the
//                     registered num_free only. A source that is not ready
//                     carries its tag in the low TAG_W bits.
//   cdb_*           : CDB_W broadcast lanes (tag, data)
//   fu_ready        : per issue port, the FU accepts this cycle
//   issue_*         : combinational grant outputs, one per port
//   num_free        : registered count of free entries
module rs_age_issue import rs_pkg::*; #(
  parameter int DEPTH   = RS_DEPTH,
  parameter int DISP_W  = 2,
  parameter int ISSUE_W = 2,
  parameter int CDB_W   = 2,
  parameter int XLEN    = RS_XLEN,
  parameter int TAG_W   = 6,
  parameter int PKT_W   = RS_PKT_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            squash,
  input  logic [DISP_W-1:0]               disp_valid,
  output logic                            disp_ready,
  input  logic [DISP_W-1:0][PKT_W-1:0]    disp_pkt,
  input  logic [DISP_W-1:0][XLEN-1:0]     disp_src1_val,
  input  logic [DISP_W-1:0][XLEN-1:0]     disp_src2_val,
  input  logic [DISP_W-1:0]               disp_src1_rdy,
  input  logic [DISP_W-1:0]               disp_src2_rdy,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]     cdb_tag,
  input  logic [CDB_W-1:0][XLEN-1:0]      cdb_data,
  input  logic [ISSUE_W-1:0]              fu_ready,
  output logic [ISSUE_W-1:0]              issue_valid,
  output logic [ISSUE_W-1:0][PKT_W-1:0]   issue_pkt,
  output logic [ISSUE_W-1:0][XLEN-1:0]    issue_src1,
  output logic [ISSUE_W-1:0][XLEN-1:0]    issue_src2,
  output logic [$clog2(DEPTH):0]          num_free
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  rs_entry_t [DEPTH-1:0]         ent_q, ent_nxt;
  rs_entry_t [DISP_W-1:0]        disp_ent;
  logic [DEPTH-1:0]              valid_vec, elig, alloc, grant;
  logic [DISP_W-1:0][DEPTH-1:0]  slot_oh;
  logic [DEPTH-1:0][CNT_W-1:0]   older_cnt;
  logic [CNT_W-1:0]              n_disp, n_iss, num_free_nxt;

  // CDB snoop. Returns {rdy, value}. A later lane overwrites an earlier
  // one, so the highest matching lane wins.
  function automatic logic [XLEN:0] snoop(input logic [XLEN-1:0] v, input logic rdy);
    logic [XLEN:0] r;
    r = {rdy, v};
    if (!rdy)
      for (int l = 0; l < CDB_W; l++)
        if (cdb_valid[l] && cdb_tag[l] == v[TAG_W-1:0]) r = {1'b1, cdb_data[l]};
    return r;
  endfunction

  assign disp_ready = (num_free >= CNT_W'(DISP_W));

  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      valid_vec[n] = ent_q[n].valid;
      elig[n]      = ent_q[n].valid & ent_q[n].src1_rdy & ent_q[n].src2_rdy;
    end
  end

  // Fired slots claim the lowest free entries in slot order. Entries freed
  // by this cycle's issue still read as valid here, so they are not reused
  // until the next cycle.
  always_comb begin
    logic [DEPTH-1:0] taken;
    taken   = valid_vec;
    slot_oh = '0;
    for (int k = 0; k < DISP_W; k++)
      if (disp_valid[k] && disp_ready && !squash)
        for (int n = 0; n < DEPTH; n++)
          if (!taken[n] && slot_oh[k] == '0) begin
            slot_oh[k][n] = 1'b1;
            taken[n]      = 1'b1;
          end
    alloc = taken & ~valid_vec;
  end

  always_comb begin
    for (int k = 0; k < DISP_W; k++) begin
      disp_ent[k].valid = 1'b1;
      disp_ent[k].pkt   = disp_pkt[k];
      {disp_ent[k].src1_rdy, disp_ent[k].src1} = snoop(disp_src1_val[k], disp_src1_rdy[k]);
      {disp_ent[k].src2_rdy, disp_ent[k].src2} = snoop(disp_src2_val[k], disp_src2_rdy[k]);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_age (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid_vec),
    .alloc     (alloc),
    .elig      (elig),
    .older_cnt (older_cnt)
  );

  // The k-th ready port (counting only ports with fu_ready) takes the
  // eligible entry that has exactly k older eligible entries.
  always_comb begin
    logic [CNT_W-1:0] rank;
    rank        = '0;
    grant       = '0;
    issue_valid = '0;
    issue_pkt   = '0;
    issue_src1  = '0;
    issue_src2  = '0;
    for (int p = 0; p < ISSUE_W; p++)
      if (fu_ready[p]) begin
        for (int n = 0; n < DEPTH; n++)
          if (elig[n] && older_cnt[n] == rank) begin
            grant[n]       = 1'b1;
            issue_valid[p] = 1'b1;
            issue_pkt[p]   = ent_q[n].pkt;
            issue_src1[p]  = ent_q[n].src1;
            issue_src2[p]  = ent_q[n].src2;
          end
        rank = rank + 1'b1;
      end
  end

  // Next entry state. Priority, lowest to highest: wakeup, free on
  // grant, dispatch write, squash.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      ent_nxt[n] = ent_q[n];
      {ent_nxt[n].src1_rdy, ent_nxt[n].src1} = snoop(ent_q[n].src1, ent_q[n].src1_rdy);
      {ent_nxt[n].src2_rdy, ent_nxt[n].src2} = snoop(ent_q[n].src2, ent_q[n].src2_rdy);
      if (grant[n]) ent_nxt[n].valid = 1'b0;
      for (int k = 0; k < DISP_W; k++)
        if (slot_oh[k][n]) ent_nxt[n] = disp_ent[k];
      if (squash) ent_nxt[n].valid = 1'b0;
    end
  end

  always_comb begin
    n_disp = '0;
    n_iss  = '0;
    for (int n = 0; n < DEPTH; n++) begin
      n_disp = n_disp + CNT_W'(alloc[n]);
      n_iss  = n_iss + CNT_W'(grant[n]);
    end
    num_free_nxt = squash ? CNT_W'(DEPTH) : num_free - n_disp + n_iss;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_q    <= '0;
      num_free <= CNT_W'(DEPTH);
    end else begin
      ent_q    <= ent_nxt;
      num_free <= num_free_nxt;
    end
  end

  // An underflow would wrap to a value above DEPTH, so this one bound
  // covers both directions.
  assert property (@(posedge clock) disable iff (reset) num_free <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_rs_age_issue.sv
module tb_rs_age_issue;
  logic             clock = 1'b0;
  logic             reset;
  logic             squash;
  logic [1:0]       disp_valid;
  logic             disp_ready;
  logic [1:0][63:0] disp_pkt;
  logic [1:0][31:0] disp_src1_val, disp_src2_val;
  logic [1:0]       disp_src1_rdy, disp_src2_rdy;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag;
  logic [1:0][31:0] cdb_data;
  logic [1:0]       fu_ready;
  logic [1:0]       issue_valid;
  logic [1:0][63:0] issue_pkt;
  logic [1:0][31:0] issue_src1, issue_src2;
  logic [4:0]       num_free;

  rs_age_issue dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_pkt(issue_pkt),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .num_free(num_free)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          cyc;
    int          port;
    logic [63:0] pkt;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_push(input int c, input int p, input logic [63:0] pkt,
                          input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    e.cyc = c; e.port = p; e.pkt = pkt; e.s1 = s1; e.s2 = s2;
    q.push_back(e);
  endtask

  // Issue monitor: every valid port must match the next expected grant.
  // Expectations that come due without a matching issue count as missed.
  always @(negedge clock) begin
    exp_t e;
    for (int p = 0; p < 2; p++)
      if (issue_valid[p]) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_issue: port %0d pkt %0h at cycle %0d, none expected", p, issue_pkt[p], cyc);
        end else begin
          e = q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_port", 64'(p), 64'(e.port));
          chk("issue_pkt", issue_pkt[p], e.pkt);
          chk("issue_src1", 64'(issue_src1[p]), 64'(e.s1));
          chk("issue_src2", 64'(issue_src2[p]), 64'(e.s2));
        end
      end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      $display("FAIL missed_issue: got nothing expected pkt %0h on port %0d at cycle %0d", e.pkt, e.port, e.cyc);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle_in();
    disp_valid = '0; cdb_valid = '0; squash = 1'b0;
  endtask

  task automatic slot(input int k, input logic [63:0] pkt, input logic [31:0] v1, input logic r1,
                      input logic [31:0] v2, input logic r2);
    disp_valid[k] = 1'b1; disp_pkt[k] = pkt;
    disp_src1_val[k] = v1; disp_src1_rdy[k] = r1;
    disp_src2_val[k] = v2; disp_src2_rdy[k] = r2;
  endtask

  task automatic cdb(input int l, input logic [5:0] tag, input logic [31:0] data);
    cdb_valid[l] = 1'b1; cdb_tag[l] = tag; cdb_data[l] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0; disp_valid = '0; disp_pkt = '0;
    disp_src1_val = '0; disp_src2_val = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; fu_ready = '0;
    @(negedge clock);
    chk("rst_num_free", 64'(num_free), 64'd16);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    tick(); reset = 1'b0;
    @(negedge clock);
    chk("idle_num_free", 64'(num_free), 64'd16);
    chk("idle_disp_ready", 64'(disp_ready), 64'd1);
    chk("idle_issue_valid", 64'(issue_valid), 64'd0);
    tick();

    // A then B, both ready, issued together once the FUs open up.
    slot(0, 64'hA, 32'h1, 1'b1, 32'h2, 1'b1); tick();
    idle_in(); slot(0, 64'hB, 32'h3, 1'b1, 32'h4, 1'b1);
    @(negedge clock); chk("ab_num_free_c1", 64'(num_free), 64'd15); tick();
    idle_in(); fu_ready = 2'b11;
    exp_push(cyc, 0, 64'hA, 32'h1, 32'h2);
    exp_push(cyc, 1, 64'hB, 32'h3, 32'h4);
    @(negedge clock); chk("ab_num_free_c2", 64'(num_free), 64'd14); tick();

    // C waits on tag 5. The CDB arrives one cycle later and C issues the
    // cycle after that; there is no same-cycle bypass.
    @(negedge clock); chk("ab_num_free_c3", 64'(num_free), 64'd16); tick();
    slot(0, 64'hC, 32'd5, 1'b0, 32'h7, 1'b1); tick();
    idle_in(); cdb(0, 6'd5, 32'hDEAD); cdb(1, 6'd6, 32'hBEEF);
    @(negedge clock); chk("c_num_free", 64'(num_free), 64'd15); tick();
    idle_in(); exp_push(cyc, 0, 64'hC, 32'hDEAD, 32'h7); tick();

    // D goes in on slot 1 only, and the CDB forwards its tag in the dispatch cycle.
    slot(1, 64'hD, 32'h11, 1'b1, 32'd9, 1'b0); cdb(1, 6'd9, 32'h1234);
    exp_push(cyc + 1, 0, 64'hD, 32'h11, 32'h1234); tick();
    idle_in();
    @(negedge clock); chk("d_num_free", 64'(num_free), 64'd15); tick();
    @(negedge clock); chk("d_num_free_after", 64'(num_free), 64'd16);

    // Two lanes carry the same tag: the higher lane's data is captured.
    fu_ready = 2'b00; slot(0, 64'hE, 32'd12, 1'b0, 32'h0, 1'b1); tick();
    idle_in(); cdb(0, 6'd12, 32'h1111); cdb(1, 6'd12, 32'h2222); tick();
    idle_in(); fu_ready = 2'b01; exp_push(cyc, 0, 64'hE, 32'h2222, 32'h0); tick();
    fu_ready = 2'b00;

    // Fill to 15 entries, then try a dispatch that must be dropped.
    for (int c = 0; c < 8; c++) begin
      idle_in();
      slot(0, 64'(100 + 2*c), 32'(2*c), 1'b1, 32'(1000 + 2*c), 1'b1);
      if (c < 7) slot(1, 64'(101 + 2*c), 32'(2*c + 1), 1'b1, 32'(1001 + 2*c), 1'b1);
      tick();
    end
    idle_in(); slot(0, 64'd999, 32'h0, 1'b1, 32'h0, 1'b1); slot(1, 64'd998, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge clock);
    chk("full_num_free", 64'(num_free), 64'd1);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    tick();

    // Drain: port 1 alone, then port 0 alone, then both. G lands in the
    // freed entry 0 but is the youngest, so it must issue last.
    begin
      int nxt = 0;
      for (int c = 0; c < 10; c++) begin
        idle_in();
        fu_ready = (c == 0) ? 2'b10 : (c < 4) ? 2'b01 : 2'b11;
        if (c == 1) slot(0, 64'd200, 32'h77, 1'b1, 32'h88, 1'b1);
        for (int p = 0; p < 2; p++)
          if (fu_ready[p] && nxt < 16) begin
            if (nxt < 15) exp_push(cyc, p, 64'(100 + nxt), 32'(nxt), 32'(1000 + nxt));
            else          exp_push(cyc, p, 64'd200, 32'h77, 32'h88);
            nxt++;
          end
        if (c == 0) begin
          @(negedge clock); chk("drop_num_free", 64'(num_free), 64'd1);
        end
        tick();
      end
    end
    idle_in();
    @(negedge clock); chk("drain_num_free", 64'(num_free), 64'd16); tick();

    // Eight entries wait on tags 20..27. A squash lands together with a
    // dispatch and a matching CDB, and nothing may ever issue afterwards.
    for (int c = 0; c < 4; c++) begin
      idle_in();
      slot(0, 64'(300 + 2*c), 32'(20 + 2*c), 1'b0, 32'h5, 1'b1);
      slot(1, 64'(301 + 2*c), 32'(21 + 2*c), 1'b0, 32'h5, 1'b1);
      tick();
    end
    idle_in(); squash = 1'b1; slot(0, 64'd350, 32'h1, 1'b1, 32'h2, 1'b1); cdb(0, 6'd20, 32'h42);
    @(negedge clock); chk("presquash_num_free", 64'(num_free), 64'd8); tick();
    idle_in();
    @(negedge clock);
    chk("squash_num_free", 64'(num_free), 64'd16);
    chk("squash_disp_ready", 64'(disp_ready), 64'd1);
    tick();
    for (int c = 0; c < 4; c++) begin
      idle_in(); cdb(0, 6'(20 + 2*c), 32'h9); cdb(1, 6'(21 + 2*c), 32'h9); tick();
    end
    idle_in();

    // Asynchronous reset in the middle of a cycle with grants pending.
    fu_ready = 2'b00;
    slot(0, 64'd400, 32'h1, 1'b1, 32'h1, 1'b1); slot(1, 64'd401, 32'h1, 1'b1, 32'h1, 1'b1); tick();
    slot(0, 64'd402, 32'h1, 1'b1, 32'h1, 1'b1); slot(1, 64'd403, 32'h1, 1'b1, 32'h1, 1'b1); tick();
    idle_in(); fu_ready = 2'b11; #1;
    chk("prereset_issue_valid", 64'(issue_valid), 64'd3);
    chk("prereset_num_free", 64'(num_free), 64'd12);
    reset = 1'b1; #1;
    chk("async_issue_valid", 64'(issue_valid), 64'd0);
    chk("async_num_free", 64'(num_free), 64'd16);
    chk("async_disp_ready", 64'(disp_ready), 64'd1);
    tick(); reset = 1'b0;
    tick(); tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
